// File: rtl/sdp_bram_arbiter.sv
// ============================================================================
// Module   : sdp_bram_arbiter
// Brief    : Shares one simple-dual-port BRAM (1 write port, 1 read port with
//            1-cycle synchronous read) between two requesters. The write and
//            read ports are arbitrated independently, each with its own
//            round-robin pointer. Read data is returned tagged with the ID of
//            the requester that owns it.
// Options  : SDP_ARB_RAW_BYPASS_EN
//              defined   - a read that hits the address being written in the
//                          same cycle is granted, and the write data is
//                          forwarded to rd_data on the following cycle.
//              undefined - the colliding read is held off for that cycle and
//                          retries, so it then reads the new data from RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdp_bram_arbiter #(
  parameter int ABITS = 10,
  parameter int DBITS = 36
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           wr_req,
  input  logic [2*ABITS-1:0]   wr_addr,
  input  logic [2*DBITS-1:0]   wr_data,
  output logic [1:0]           wr_gnt,
  input  logic [1:0]           rd_req,
  input  logic [2*ABITS-1:0]   rd_addr,
  output logic [1:0]           rd_gnt,
  output logic                 rd_valid,
  output logic                 rd_id,
  output logic [DBITS-1:0]     rd_data,
  output logic                 ram_we,
  output logic [ABITS-1:0]     ram_wa,
  output logic [DBITS-1:0]     ram_wd,
  output logic [ABITS-1:0]     ram_ra,
  input  logic [DBITS-1:0]     ram_rd
);

  // Round-robin pick between two requesters: the preferred one wins if it
  // is asking, otherwise the other one gets the grant if it is asking.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
    logic [1:0] gnt;
    gnt = 2'b00;
    if (req[ptr]) begin
      gnt[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      gnt[~ptr] = 1'b1;
    end
    return gnt;
  endfunction

  // Priority pointers and read-return state
  logic             r_wptr;
  logic             r_rptr;
  logic [ABITS-1:0] r_ra_hold;
  logic             r_rd_valid;
  logic             r_rd_id;

  // Per-requester unpacked views of the packed address/data buses
  logic [ABITS-1:0] w_wa  [2];
  logic [DBITS-1:0] w_wd  [2];
  logic [ABITS-1:0] w_ra  [2];
  logic [1:0]       w_hit;
  logic [1:0]       w_rd_cand;

  // Unpack buses and flag reads that target the address being written now
  for (genvar n = 0; n < 2; n++) begin : g_req
    assign w_wa[n]  = wr_addr[n*ABITS +: ABITS];
    assign w_wd[n]  = wr_data[n*DBITS +: DBITS];
    assign w_ra[n]  = rd_addr[n*ABITS +: ABITS];
    assign w_hit[n] = ram_we && (w_ra[n] == ram_wa);
  end

  // Write grant: round-robin over the raw requests, forced off in reset
  always_comb begin
    wr_gnt = 2'b00;
    if (!rst) begin
      wr_gnt = rr_pick(wr_req, r_wptr);
    end
  end

  // Write port drive; with no grant the fields of requester 0 pass through
  always_comb begin
    ram_we = |wr_gnt;
    ram_wa = wr_gnt[1] ? w_wa[1] : w_wa[0];
    ram_wd = wr_gnt[1] ? w_wd[1] : w_wd[0];
  end

`ifdef SDP_ARB_RAW_BYPASS_EN
  // Colliding reads compete normally; the forwarding path covers the hazard
  assign w_rd_cand = rd_req;
`else
  // Colliding reads sit out this cycle and retry once the write has landed
  assign w_rd_cand = rd_req & ~w_hit;
`endif

  // Read grant: round-robin over the eligible candidates, forced off in reset
  always_comb begin
    rd_gnt = 2'b00;
    if (!rst) begin
      rd_gnt = rr_pick(w_rd_cand, r_rptr);
    end
  end

  // Read address: granted reader's address, otherwise the last one issued
  always_comb begin
    ram_ra = r_ra_hold;
    if (rd_gnt[1]) begin
      ram_ra = w_ra[1];
    end else if (rd_gnt[0]) begin
      ram_ra = w_ra[0];
    end
  end

  // Pointer update: after serving requester n, prefer the other one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
    end else begin
      if (|wr_gnt) begin
        r_wptr <= ~wr_gnt[1];
      end
      if (|rd_gnt) begin
        r_rptr <= ~rd_gnt[1];
      end
    end
  end

  // Hold the last issued read address and track the one-cycle read return
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ra_hold  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_id    <= 1'b0;
    end else begin
      if (|rd_gnt) begin
        r_ra_hold <= ram_ra;
      end
      r_rd_valid <= |rd_gnt;
      r_rd_id    <= rd_gnt[1];
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_id    = r_rd_id;

`ifdef SDP_ARB_RAW_BYPASS_EN
  logic             r_byp_flag;
  logic [DBITS-1:0] r_byp_data;
  logic             w_byp_set;

  // A granted read that collides with the current write needs forwarding
  assign w_byp_set = rd_gnt[1] ? w_hit[1] : (rd_gnt[0] & w_hit[0]);

  // Capture the write data for a colliding read; the flag lives one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byp_flag <= 1'b0;
      r_byp_data <= '0;
    end else begin
      r_byp_flag <= w_byp_set;
      if (w_byp_set) begin
        r_byp_data <= ram_wd;
      end
    end
  end

  // Return forwarded data in place of the stale RAM output when flagged
  always_comb begin
    rd_data = r_byp_flag ? r_byp_data : ram_rd;
  end
`else
  // Return the RAM output directly; collisions never reach the RAM read
  always_comb begin
    rd_data = ram_rd;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sdp_bram_arbiter.sv
// ============================================================================
// Module   : tb_sdp_bram_arbiter
// Brief    : Directed self-checking bench for sdp_bram_arbiter with a small
//            read-first BRAM model. Honours SDP_ARB_RAW_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdp_bram_arbiter;

  localparam int ABITS = 10;
  localparam int DBITS = 36;

  logic                 clk;
  logic                 rst;
  logic [1:0]           wr_req;
  logic [2*ABITS-1:0]   wr_addr;
  logic [2*DBITS-1:0]   wr_data;
  logic [1:0]           wr_gnt;
  logic [1:0]           rd_req;
  logic [2*ABITS-1:0]   rd_addr;
  logic [1:0]           rd_gnt;
  logic                 rd_valid;
  logic                 rd_id;
  logic [DBITS-1:0]     rd_data;
  logic                 ram_we;
  logic [ABITS-1:0]     ram_wa;
  logic [DBITS-1:0]     ram_wd;
  logic [ABITS-1:0]     ram_ra;
  logic [DBITS-1:0]     ram_rd;

  int n_checks;
  int n_errors;

  sdp_bram_arbiter #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_gnt   (wr_gnt),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_gnt   (rd_gnt),
    .rd_valid (rd_valid),
    .rd_id    (rd_id),
    .rd_data  (rd_data),
    .ram_we   (ram_we),
    .ram_wa   (ram_wa),
    .ram_wd   (ram_wd),
    .ram_ra   (ram_ra),
    .ram_rd   (ram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first BRAM model; never-written locations return a fixed pattern
  logic [DBITS-1:0] mem [1024];
  logic [1023:0]    written;
  logic             mem_clr;

  function automatic logic [DBITS-1:0] pat(input logic [ABITS-1:0] a);
    return 36'h5000 + {26'd0, a} + {26'd0, a} + {26'd0, a};
  endfunction

  always @(posedge clk) begin
    if (mem_clr) begin
      written <= '0;
    end else if (ram_we) begin
      mem[ram_wa]     <= ram_wd;
      written[ram_wa] <= 1'b1;
    end
    ram_rd <= written[ram_ra] ? mem[ram_ra] : pat(ram_ra);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_wr(input logic [1:0] r, input logic [ABITS-1:0] a0, input logic [ABITS-1:0] a1,
                        input logic [DBITS-1:0] d0, input logic [DBITS-1:0] d1);
    wr_req  = r;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
  endtask

  task automatic set_rd(input logic [1:0] r, input logic [ABITS-1:0] a0, input logic [ABITS-1:0] a1);
    rd_req  = r;
    rd_addr = {a1, a0};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    mem_clr  = 1'b1;
    set_wr(2'b11, 10'd1, 10'd2, 36'h1, 36'h2);
    set_rd(2'b11, 10'd1, 10'd2);
    #2;
    // In reset: no grants even with requests present, held read address 0
    chk("rst_wr_gnt", 64'(wr_gnt), 64'h0);
    chk("rst_rd_gnt", 64'(rd_gnt), 64'h0);
    chk("rst_ram_we", 64'(ram_we), 64'h0);
    chk("rst_rd_valid", 64'(rd_valid), 64'h0);
    chk("rst_ram_ra", 64'(ram_ra), 64'h0);
    @(posedge clk);
    @(posedge clk);
    mem_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    set_wr(2'b00, '0, '0, '0, '0);
    set_rd(2'b00, '0, '0);
    tick;

    // Basic write then read-back with 1-cycle latency
    set_wr(2'b01, 10'd5, 10'd0, 36'hABC, 36'h0);
    #1;
    chk("t1_wr_gnt", 64'(wr_gnt), 64'h1);
    chk("t1_ram_we", 64'(ram_we), 64'h1);
    chk("t1_ram_wa", 64'(ram_wa), 64'd5);
    chk("t1_ram_wd", 64'(ram_wd), 64'hABC);
    tick;
    set_wr(2'b00, 10'h11, 10'h22, 36'h0, 36'h0);
    set_rd(2'b01, 10'd5, 10'd0);
    #1;
    chk("t1_rd_gnt", 64'(rd_gnt), 64'h1);
    chk("t1_ram_ra", 64'(ram_ra), 64'd5);
    chk("t1_idle_we", 64'(ram_we), 64'h0);
    chk("t1_idle_wa", 64'(ram_wa), 64'h11);
    tick;
    set_rd(2'b00, 10'd0, 10'd0);
    #1;
    chk("t1_rd_valid", 64'(rd_valid), 64'h1);
    chk("t1_rd_id", 64'(rd_id), 64'h0);
    chk("t1_rd_data", 64'(rd_data), 64'hABC);
    chk("t1_ra_hold", 64'(ram_ra), 64'd5);
    tick;
    chk("t1_valid_drop", 64'(rd_valid), 64'h0);

    // Round-robin writes; both pointers now prefer requester 1
    for (int k = 0; k < 4; k++) begin
      set_wr(2'b11, 10'd20, 10'd21, 36'h100 + 36'(k), 36'h200 + 36'(k));
      #1;
      chk("t2_wr_gnt", 64'(wr_gnt), (k % 2 == 0) ? 64'h2 : 64'h1);
      chk("t2_ram_wa", 64'(ram_wa), (k % 2 == 0) ? 64'd21 : 64'd20);
      tick;
    end
    set_wr(2'b00, '0, '0, '0, '0);
    // Round-robin reads: mem[21]=0x202, mem[20]=0x103
    for (int k = 0; k < 4; k++) begin
      set_rd(2'b11, 10'd20, 10'd21);
      #1;
      if (k > 0) begin
        chk("t2_rd_valid", 64'(rd_valid), 64'h1);
        chk("t2_rd_id", 64'(rd_id), ((k - 1) % 2 == 0) ? 64'h1 : 64'h0);
        chk("t2_rd_data", 64'(rd_data), ((k - 1) % 2 == 0) ? 64'h202 : 64'h103);
      end
      chk("t2_rd_gnt", 64'(rd_gnt), (k % 2 == 0) ? 64'h2 : 64'h1);
      tick;
    end
    set_rd(2'b00, '0, '0);
    #1;
    chk("t2_last_id", 64'(rd_id), 64'h0);
    chk("t2_last_data", 64'(rd_data), 64'h103);
    tick;

    // Same-cycle write addr 7 (req 0) and read addr 7 (req 1)
    set_wr(2'b01, 10'd7, 10'd0, 36'h123, 36'h0);
    set_rd(2'b10, 10'd0, 10'd7);
    #1;
    chk("t3_wr_gnt", 64'(wr_gnt), 64'h1);
`ifdef SDP_ARB_RAW_BYPASS_EN
    chk("t3_rd_gnt", 64'(rd_gnt), 64'h2);
    tick;
    set_wr(2'b00, '0, '0, '0, '0);
    set_rd(2'b00, '0, '0);
    #1;
    chk("t3_rd_valid", 64'(rd_valid), 64'h1);
    chk("t3_rd_id", 64'(rd_id), 64'h1);
    chk("t3_rd_data", 64'(rd_data), 64'h123);
`else
    chk("t3_rd_gnt", 64'(rd_gnt), 64'h0);
    chk("t3_ra_hold", 64'(ram_ra), 64'd20);
    tick;
    set_wr(2'b00, '0, '0, '0, '0);
    #1;
    chk("t3_no_valid", 64'(rd_valid), 64'h0);
    chk("t3_retry_gnt", 64'(rd_gnt), 64'h2);
    chk("t3_retry_ra", 64'(ram_ra), 64'd7);
    tick;
    set_rd(2'b00, '0, '0);
    #1;
    chk("t3_rd_valid", 64'(rd_valid), 64'h1);
    chk("t3_rd_id", 64'(rd_id), 64'h1);
    chk("t3_rd_data", 64'(rd_data), 64'h123);
`endif
    tick;

    // Write addr 3 (req 0) with reads addr 3 (req 0) and addr 9 (req 1), rptr=0
    set_wr(2'b01, 10'd3, 10'd0, 36'h333, 36'h0);
    set_rd(2'b11, 10'd3, 10'd9);
    #1;
`ifdef SDP_ARB_RAW_BYPASS_EN
    chk("t4_rd_gnt", 64'(rd_gnt), 64'h1);
    chk("t4_ram_ra", 64'(ram_ra), 64'd3);
    tick;
    set_wr(2'b00, '0, '0, '0, '0);
    set_rd(2'b00, '0, '0);
    #1;
    chk("t4_rd_id", 64'(rd_id), 64'h0);
    chk("t4_rd_data", 64'(rd_data), 64'h333);
`else
    chk("t4_rd_gnt", 64'(rd_gnt), 64'h2);
    chk("t4_ram_ra", 64'(ram_ra), 64'd9);
    tick;
    set_wr(2'b00, '0, '0, '0, '0);
    set_rd(2'b01, 10'd3, 10'd9);
    #1;
    chk("t4_rd_id", 64'(rd_id), 64'h1);
    chk("t4_rd_data", 64'(rd_data), 64'h501B);
    chk("t4_retry_gnt", 64'(rd_gnt), 64'h1);
    tick;
    set_rd(2'b00, '0, '0);
    #1;
    chk("t4_retry_id", 64'(rd_id), 64'h0);
    chk("t4_retry_data", 64'(rd_data), 64'h333);
`endif
    tick;

    // Asynchronous reset with a read in flight
    set_rd(2'b01, 10'd3, 10'd0);
    #1;
    chk("t5_rd_gnt", 64'(rd_gnt), 64'h1);
    tick;
    rst = 1'b1;
    #1;
    chk("t5_async_valid", 64'(rd_valid), 64'h0);
    chk("t5_rst_rd_gnt", 64'(rd_gnt), 64'h0);
    chk("t5_rst_ram_ra", 64'(ram_ra), 64'h0);
    tick;
    chk("t5_rst_valid2", 64'(rd_valid), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    set_rd(2'b00, '0, '0);
    tick;
    chk("t5_post_valid", 64'(rd_valid), 64'h0);
    set_wr(2'b11, 10'd30, 10'd31, 36'h777, 36'h888);
    set_rd(2'b11, 10'd7, 10'd3);
    #1;
    chk("t5_wptr_reset", 64'(wr_gnt), 64'h1);
    chk("t5_rptr_reset", 64'(rd_gnt), 64'h1);
    chk("t5_ram_ra", 64'(ram_ra), 64'd7);
    tick;
    set_wr(2'b00, '0, '0, '0, '0);
    set_rd(2'b00, '0, '0);
    #1;
    chk("t5_rd_valid", 64'(rd_valid), 64'h1);
    chk("t5_rd_id", 64'(rd_id), 64'h0);
    chk("t5_rd_data", 64'(rd_data), 64'h123);
    tick;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
